// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- instruction decode stage of the 5-stage MIPS pipeline.
//
// Decodes the IF/ID instruction into control bits, reads the 32x32 register
// file (with write-through from write-back), detects load-use hazards and
// registers everything into the ID/EX pipeline register.
//
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   IF_ID_NEXT_ADR/IF_ID_INST  PC+4 and instruction from IF/ID
//   WB_REG_WRITE/WB_WRITE_REG/WB_WRITE_DATA  register-file write port
//   FLUSH                      squash the instruction currently in ID
//   STALL                      combinational; hold PC and IF/ID
//   ID_EX_*                    registered decode results
// -----------------------------------------------------------------------------
module id_stage #(
    parameter int XLEN    = 32,
    parameter int REG_CNT = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [XLEN-1:0] IF_ID_NEXT_ADR,
    input  logic [XLEN-1:0] IF_ID_INST,
    input  logic            WB_REG_WRITE,
    input  logic [4:0]      WB_WRITE_REG,
    input  logic [XLEN-1:0] WB_WRITE_DATA,
    input  logic            FLUSH,
    output logic            STALL,
    output logic [XLEN-1:0] ID_EX_NEXT_ADR,
    output logic [XLEN-1:0] ID_EX_READ_DATA_1,
    output logic [XLEN-1:0] ID_EX_READ_DATA_2,
    output logic [XLEN-1:0] ID_EX_SIGN_EXT,
    output logic [4:0]      ID_EX_RS,
    output logic [4:0]      ID_EX_RT,
    output logic [4:0]      ID_EX_RD,
    output logic            ID_EX_REG_DST,
    output logic            ID_EX_ALU_SRC,
    output logic            ID_EX_MEM_TO_REG,
    output logic            ID_EX_REG_WRITE,
    output logic            ID_EX_MEM_READ,
    output logic            ID_EX_MEM_WRITE,
    output logic            ID_EX_BRANCH,
    output logic [1:0]      ID_EX_ALU_OP
);

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Instruction fields
    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    assign opcode = IF_ID_INST[31:26];
    assign rs     = IF_ID_INST[25:21];
    assign rt     = IF_ID_INST[20:16];
    assign rd     = IF_ID_INST[15:11];

    // Register file
    logic [XLEN-1:0] regs_q [REG_CNT];
    logic [XLEN-1:0] regs_d [REG_CNT];
    logic            wb_en;

    assign wb_en = WB_REG_WRITE && (WB_WRITE_REG != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wb_en) regs_d[WB_WRITE_REG] = WB_WRITE_DATA;
    end

    // Reads see a same-cycle write-back so ID never captures stale data.
    logic [XLEN-1:0] rd_data_1, rd_data_2;
    always_comb begin
        rd_data_1 = '0;
        rd_data_2 = '0;
        if (rs != 5'd0) rd_data_1 = (wb_en && WB_WRITE_REG == rs) ? WB_WRITE_DATA : regs_q[rs];
        if (rt != 5'd0) rd_data_2 = (wb_en && WB_WRITE_REG == rt) ? WB_WRITE_DATA : regs_q[rt];
    end

    // Control decode
    ctrl_t ctrl_dec;
    always_comb begin
        ctrl_dec = '0;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl_dec.reg_dst   = 1'b1;
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = 2'b10;
            end
            OP_LW: begin
                ctrl_dec.alu_src    = 1'b1;
                ctrl_dec.mem_to_reg = 1'b1;
                ctrl_dec.reg_write  = 1'b1;
                ctrl_dec.mem_read   = 1'b1;
            end
            OP_SW: begin
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_dec.branch = 1'b1;
                ctrl_dec.alu_op = 2'b01;
            end
            OP_ADDI: begin
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.reg_write = 1'b1;
            end
            default: ctrl_dec = '0;
        endcase
    end

    // ID/EX register
    ctrl_t           ctrl_q, ctrl_d;
    logic [XLEN-1:0] next_adr_q, next_adr_d;
    logic [XLEN-1:0] read_data_1_q, read_data_1_d;
    logic [XLEN-1:0] read_data_2_q, read_data_2_d;
    logic [XLEN-1:0] sign_ext_q, sign_ext_d;
    logic [4:0]      rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;

    // Load in EX whose destination feeds this instruction: one bubble.
    // A flush squashes the consumer anyway, so it never needs to wait.
    logic stall;
    assign stall = ctrl_q.mem_read && (rt_q != 5'd0) &&
                   ((rt_q == rs) || (rt_q == rt)) && !FLUSH;
    assign STALL = stall;

    always_comb begin
        ctrl_d        = (FLUSH || stall) ? ctrl_t'('0) : ctrl_dec;
        next_adr_d    = IF_ID_NEXT_ADR;
        read_data_1_d = rd_data_1;
        read_data_2_d = rd_data_2;
        sign_ext_d    = {{(XLEN-16){IF_ID_INST[15]}}, IF_ID_INST[15:0]};
        rs_d          = rs;
        rt_d          = rt;
        rd_d          = rd;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
            ctrl_q        <= '0;
            next_adr_q    <= '0;
            read_data_1_q <= '0;
            read_data_2_q <= '0;
            sign_ext_q    <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
        end else begin
            regs_q        <= regs_d;
            ctrl_q        <= ctrl_d;
            next_adr_q    <= next_adr_d;
            read_data_1_q <= read_data_1_d;
            read_data_2_q <= read_data_2_d;
            sign_ext_q    <= sign_ext_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
        end
    end

    assign ID_EX_NEXT_ADR    = next_adr_q;
    assign ID_EX_READ_DATA_1 = read_data_1_q;
    assign ID_EX_READ_DATA_2 = read_data_2_q;
    assign ID_EX_SIGN_EXT    = sign_ext_q;
    assign ID_EX_RS          = rs_q;
    assign ID_EX_RT          = rt_q;
    assign ID_EX_RD          = rd_q;
    assign ID_EX_REG_DST     = ctrl_q.reg_dst;
    assign ID_EX_ALU_SRC     = ctrl_q.alu_src;
    assign ID_EX_MEM_TO_REG  = ctrl_q.mem_to_reg;
    assign ID_EX_REG_WRITE   = ctrl_q.reg_write;
    assign ID_EX_MEM_READ    = ctrl_q.mem_read;
    assign ID_EX_MEM_WRITE   = ctrl_q.mem_write;
    assign ID_EX_BRANCH      = ctrl_q.branch;
    assign ID_EX_ALU_OP      = ctrl_q.alu_op;

endmodule
